// File: rtl/cuadratura_pkg.sv
// Shared types, phase encodings and successor helpers for the quadrature decoder.
package cuadratura_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } estado_t;

    // Phase encoding is {a, b}
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    // Ascending order: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] sig_asc(input logic [1:0] ph);
        logic [1:0] r;
        case (ph)
            PH_00:   r = PH_10;
            PH_10:   r = PH_11;
            PH_11:   r = PH_01;
            PH_01:   r = PH_00;
            default: r = PH_00;
        endcase
        return r;
    endfunction

    // Descending order is the exact reverse of the ascending one
    function automatic logic [1:0] sig_desc(input logic [1:0] ph);
        logic [1:0] r;
        case (ph)
            PH_00:   r = PH_01;
            PH_01:   r = PH_11;
            PH_11:   r = PH_10;
            PH_10:   r = PH_00;
            default: r = PH_00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// One-bit multi-flop synchronizer for an asynchronous input, cleared to 0 on reset.
module sincronizador #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/decodificador_cuadratura.sv
// Quadrature decoder: synchronizes A/B, tracks phase transitions and keeps
// a wrapping position, last direction, a step strobe and a sticky error flag.
module decodificador_cuadratura
    import cuadratura_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         clear,
    input  logic         err_clr,
    output logic [N-1:0] pos,
    output logic         dir,
    output logic         step,
    output logic         err
);

    localparam int            CW       = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SYNC_STAGES);

    logic         a_s;
    logic         b_s;
    logic [1:0]   ph_s;

    estado_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]   prev_q, prev_d;
    logic [N-1:0] pos_q, pos_d;
    logic         dir_q, dir_d;
    logic         step_q, step_d;
    logic         err_q, err_d;

    sincronizador #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .d_i   (a_in),
        .q_o   (a_s)
    );

    sincronizador #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .d_i   (b_in),
        .q_o   (b_s)
    );

    assign ph_s = {a_s, b_s};

    // State, phase history and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            prev_q  <= PH_00;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    // Next-state: init window, transition classification, clear/err_clr priority
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = ph_s;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        // err_clr is applied first so that a same-cycle illegal transition wins
        if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_INIT: begin
                // Absorb whatever phase the encoder sits at after reset
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_TRACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_TRACK: begin
                if (ph_s == prev_q) begin
                    step_d = 1'b0;
                end else if (ph_s == sig_asc(prev_q)) begin
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                    pos_d  = pos_q + N'(1);
                end else if (ph_s == sig_desc(prev_q)) begin
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                    pos_d  = pos_q - N'(1);
                end else begin
                    // Both phases moved: flag it and resynchronize on the new phase
                    err_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase

        if (clear) begin
            pos_d = '0;
        end else begin
            pos_d = pos_d;
        end
    end

    assign pos  = pos_q;
    assign dir  = dir_q;
    assign step = step_q;
    assign err  = err_q;

endmodule

// File: tb/tb_decodificador_cuadratura.sv
// Directed self-checking bench for the quadrature decoder.
module tb_decodificador_cuadratura;

    logic       clk;
    logic       reset;
    logic       a_in;
    logic       b_in;
    logic       clear;
    logic       err_clr;
    logic [7:0] pos;
    logic       dir;
    logic       step;
    logic       err;

    int         checks    = 0;
    int         errors    = 0;
    int         step_cnt  = 0;
    int         cnt_base;
    logic [7:0] pos_exp;
    logic [1:0] asc_tab  [4];
    logic [1:0] desc_tab [4];

    decodificador_cuadratura #(.N(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_in    (a_in),
        .b_in    (b_in),
        .clear   (clear),
        .err_clr (err_clr),
        .pos     (pos),
        .dir     (dir),
        .step    (step),
        .err     (err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count step pulses away from the active edge
    always @(negedge clk) begin
        if (step) step_cnt <= step_cnt + 1;
    end

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a phase at a falling edge and hold it four clocks
    task automatic mover(input logic [1:0] ph);
        {a_in, b_in} = ph;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        asc_tab  = '{2'b10, 2'b11, 2'b01, 2'b00};
        desc_tab = '{2'b01, 2'b11, 2'b10, 2'b00};
        reset   = 1'b1;
        a_in    = 1'b1;
        b_in    = 1'b1;
        clear   = 1'b0;
        err_clr = 1'b0;

        // Power-up with encoder sitting at 11
        repeat (3) @(negedge clk);
        comprobar("rst_pos", 32'(pos), 32'h0);
        comprobar("rst_dir", 32'(dir), 32'h0);
        comprobar("rst_step", 32'(step), 32'h0);
        comprobar("rst_err", 32'(err), 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        comprobar("pwr_pos", 32'(pos), 32'h0);
        comprobar("pwr_err", 32'(err), 32'h0);
        comprobar("pwr_steps", 32'(step_cnt), 32'd0);

        // Restart from phase 00
        reset = 1'b1;
        a_in  = 1'b0;
        b_in  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        cnt_base = step_cnt;

        // First ascending transition: latency and single-cycle pulse
        {a_in, b_in} = 2'b10;
        @(negedge clk);
        @(negedge clk);
        comprobar("lat_step_early", 32'(step), 32'h0);
        comprobar("lat_pos_early", 32'(pos), 32'h0);
        @(negedge clk);
        comprobar("lat_step", 32'(step), 32'h1);
        comprobar("lat_pos", 32'(pos), 32'h1);
        comprobar("lat_dir", 32'(dir), 32'h0);
        @(negedge clk);
        comprobar("lat_step_off", 32'(step), 32'h0);
        pos_exp = 8'd1;

        // Remaining 15 ascending transitions
        for (int t = 1; t < 16; t++) begin
            mover(asc_tab[t % 4]);
            pos_exp = pos_exp + 8'd1;
            comprobar($sformatf("asc_pos_%0d", t), 32'(pos), 32'(pos_exp));
        end
        comprobar("asc_pos_final", 32'(pos), 32'h10);
        comprobar("asc_dir", 32'(dir), 32'h0);
        comprobar("asc_steps", 32'(step_cnt - cnt_base), 32'd16);

        // 20 descending transitions wrap through zero
        cnt_base = step_cnt;
        for (int t = 0; t < 20; t++) begin
            mover(desc_tab[t % 4]);
            pos_exp = pos_exp - 8'd1;
            comprobar($sformatf("desc_pos_%0d", t), 32'(pos), 32'(pos_exp));
        end
        comprobar("desc_pos_final", 32'(pos), 32'hFC);
        comprobar("desc_dir", 32'(dir), 32'h1);
        comprobar("desc_steps", 32'(step_cnt - cnt_base), 32'd20);

        // Illegal jump 00 -> 11
        cnt_base = step_cnt;
        mover(2'b11);
        comprobar("ill_err", 32'(err), 32'h1);
        comprobar("ill_pos", 32'(pos), 32'hFC);
        comprobar("ill_dir", 32'(dir), 32'h1);
        comprobar("ill_steps", 32'(step_cnt - cnt_base), 32'd0);

        // 11 -> 01 is the ascending successor: decoder is back in step
        mover(2'b01);
        comprobar("resync_pos", 32'(pos), 32'hFD);
        comprobar("resync_dir", 32'(dir), 32'h0);
        comprobar("resync_steps", 32'(step_cnt - cnt_base), 32'd1);

        // Second illegal 01 -> 10 registered in the same cycle as err_clr
        {a_in, b_in} = 2'b10;
        @(negedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        comprobar("errclr_set_wins", 32'(err), 32'h1);
        comprobar("errclr_no_step", 32'(step), 32'h0);
        @(negedge clk);
        err_clr = 1'b0;
        comprobar("errclr_alone", 32'(err), 32'h0);
        comprobar("errclr_pos", 32'(pos), 32'hFD);

        // Standalone clear, then climb to 5 from phase 10
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        comprobar("clear_pos", 32'(pos), 32'h0);
        comprobar("clear_dir", 32'(dir), 32'h0);
        mover(2'b11);
        mover(2'b01);
        mover(2'b00);
        mover(2'b10);
        mover(2'b11);
        comprobar("pre_clear_pos", 32'(pos), 32'h5);

        // clear in the cycle the decoder registers an ascending step
        {a_in, b_in} = 2'b01;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        comprobar("clrstep_pos", 32'(pos), 32'h0);
        comprobar("clrstep_step", 32'(step), 32'h1);
        comprobar("clrstep_dir", 32'(dir), 32'h0);
        repeat (2) @(negedge clk);

        // Build pos=9, dir=1, err=1 from phase 01
        for (int t = 0; t < 10; t++) begin
            mover(asc_tab[(t + 3) % 4]);
        end
        mover(2'b00);
        mover(2'b11);
        comprobar("pre_rst_pos", 32'(pos), 32'h9);
        comprobar("pre_rst_dir", 32'(dir), 32'h1);
        comprobar("pre_rst_err", 32'(err), 32'h1);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        comprobar("arst_pos", 32'(pos), 32'h0);
        comprobar("arst_dir", 32'(dir), 32'h0);
        comprobar("arst_step", 32'(step), 32'h0);
        comprobar("arst_err", 32'(err), 32'h0);
        @(negedge clk);
        // Encoder moves to 10 while in reset; must be absorbed by the init window
        {a_in, b_in} = 2'b10;
        @(negedge clk);
        cnt_base = step_cnt;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        comprobar("init_steps", 32'(step_cnt - cnt_base), 32'd0);
        comprobar("init_pos", 32'(pos), 32'h0);
        comprobar("init_err", 32'(err), 32'h0);

        // Tracking resumes after the init window
        mover(2'b11);
        comprobar("resume_pos", 32'(pos), 32'h1);
        comprobar("resume_steps", 32'(step_cnt - cnt_base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
